// File: rtl/count_event_tracker_pkg.sv
// Shared types for the counter event tracker: checker states and event record.
package count_trk_pkg;

  localparam int EVT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    ERROR
  } state_t;

  typedef struct packed {
    logic       err;
    logic       wrap;
    logic       match;
    logic [2:0] val;
  } evt_t;

endpackage

// File: rtl/count_event_tracker_if.sv
// Valid/ready event stream from the tracker to its consumer.
interface count_event_tracker_if;
  import count_trk_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/count_event_tracker_fifo.sv
// Small first-word-fall-through FIFO; pointers carry one extra bit for occupancy.
module count_evt_fifo
  import count_trk_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = evt_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     din,
  output logic full,
  output logic valid,
  input  logic ready,
  output T     dout
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic         pop;
  logic         accept;

  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == (AW+1)'(DEPTH));
  assign valid  = (count != '0);
  assign pop    = valid && ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign accept = push && (!full || pop);
  // Head forced to zero when empty so the output reads 0 straight after reset.
  assign dout   = valid ? mem[rd_ptr[AW-1:0]] : T'('0);

  // Pointer update on push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write for accepted pushes.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/count_event_tracker.sv
// Checks a 3-bit up-counter's +1/wrap sequence and queues match/wrap/error events.
module count_event_tracker
  import count_trk_pkg::*;
#(
  parameter logic [2:0] MATCH_VAL = 3'd5,
  parameter int         WRAP_W    = 8,
  parameter int         EVT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ctr_reset,
  input  logic [2:0]            c,
  input  logic                  clear_err,
  output logic                  match,
  output logic [WRAP_W-1:0]     wrap_cnt,
  output logic                  seq_err,
  output logic                  overflow,
  count_event_tracker_if.master evt
);

  state_t     state;
  logic [2:0] prev_c;
  logic       prev_rst;
  logic [2:0] exp_c;
  evt_t       ev;
  evt_t       head;
  logic       push;
  logic       full;
  logic       drop;

  assign exp_c = prev_rst ? 3'd0 : prev_c + 3'd1;

  // Event flags for the sampled value; a cycle with ctr_reset asserted raises none.
  always_comb begin
    ev     = '0;
    ev.val = c;
    if (state == TRACK && !ctr_reset) begin
      if (c != exp_c) begin
        ev.err = 1'b1;
      end else begin
        ev.wrap  = !prev_rst && (prev_c == 3'd7) && (c == 3'd0);
        ev.match = (c == MATCH_VAL);
      end
    end
  end

  assign push = ev.err || ev.wrap || ev.match;
  assign drop = push && full && !(evt.evt_valid && evt.evt_ready);

  // Checker FSM, previous-sample registers, wrap counter and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prev_c   <= '0;
      prev_rst <= 1'b0;
      match    <= 1'b0;
      wrap_cnt <= '0;
      seq_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_c   <= c;
      prev_rst <= ctr_reset;
      match    <= ev.match;
      case (state)
        IDLE: begin
          if (!ctr_reset) state <= TRACK;
        end
        TRACK: begin
          if (ctr_reset) begin
            wrap_cnt <= '0;
          end else if (ev.err) begin
            state <= ERROR;
          end else if (ev.wrap && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
          end
        end
        ERROR: begin
          if (clear_err) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // New violations win over a simultaneous clear.
      if (ev.err)         seq_err <= 1'b1;
      else if (clear_err) seq_err <= 1'b0;
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

  count_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (ev),
    .full    (full),
    .valid   (evt.evt_valid),
    .ready   (evt.evt_ready),
    .dout    (head)
  );

  assign evt.evt_data = head;

endmodule

// File: tb/tb_count_event_tracker.sv
// Bench for count_event_tracker: directed scenarios plus random counter traffic,
// checked every cycle against a behavioural model (two builds: MATCH_VAL 5 and 0).
module tb_count_event_tracker;
  import count_trk_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n, ctr_reset, clear_err, rdy;
  logic [2:0] c;
  logic       match0, seq0, ovf0, match1, seq1, ovf1;
  logic [7:0] wc0, wc1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [2:0] lc = 3'd7;
  logic       lr = 1'b0;

  always #5 clk = ~clk;

  count_event_tracker_if e0 ();
  count_event_tracker_if e1 ();
  assign e0.evt_ready = rdy;
  assign e1.evt_ready = rdy;

  count_event_tracker #(.MATCH_VAL(3'd5), .WRAP_W(8), .EVT_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset_n(reset_n), .ctr_reset(ctr_reset), .c(c), .clear_err(clear_err),
    .match(match0), .wrap_cnt(wc0), .seq_err(seq0), .overflow(ovf0), .evt(e0.master));

  count_event_tracker #(.MATCH_VAL(3'd0), .WRAP_W(8), .EVT_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset_n(reset_n), .ctr_reset(ctr_reset), .c(c), .clear_err(clear_err),
    .match(match1), .wrap_cnt(wc1), .seq_err(seq1), .overflow(ovf1), .evt(e1.master));

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for counter release, 1 following the count, 2 halted on error
  int         m_mode[2], m_pc[2], m_prst[2], m_match[2], m_wcnt[2];
  int         m_seq[2], m_ovf[2], m_head[2], m_cnt[2];
  logic [5:0] m_q[2][DEPTH];
  int         mv[2] = '{5, 0};

  task automatic model_clear(input int k);
    m_mode[k] = 0; m_pc[k] = 0; m_prst[k] = 0; m_match[k] = 0; m_wcnt[k] = 0;
    m_seq[k] = 0; m_ovf[k] = 0; m_head[k] = 0; m_cnt[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit e, w, mt, pop, push, drop;
    int nxt, old_mode;
    if (!reset_n) begin
      model_clear(k);
      return;
    end
    e = 0; w = 0; mt = 0;
    old_mode = m_mode[k];
    if (old_mode == 1 && !ctr_reset) begin
      nxt = m_prst[k] != 0 ? 0 : (m_pc[k] + 1) % 8;
      if (int'(c) != nxt) e = 1;
      else begin
        w  = (m_prst[k] == 0 && m_pc[k] == 7 && c == 3'd0);
        mt = (int'(c) == mv[k]);
      end
    end
    if (old_mode == 0 && !ctr_reset) m_mode[k] = 1;
    else if (old_mode == 1 && e)     m_mode[k] = 2;
    else if (old_mode == 2 && clear_err) m_mode[k] = 0;
    if (old_mode == 1 && ctr_reset) m_wcnt[k] = 0;
    else if (w && m_wcnt[k] < 255)  m_wcnt[k]++;
    if (e) m_seq[k] = 1; else if (clear_err) m_seq[k] = 0;
    pop  = (m_cnt[k] > 0) && rdy;
    push = e || w || mt;
    drop = push && (m_cnt[k] == DEPTH) && !pop;
    if (drop) m_ovf[k] = 1; else if (clear_err) m_ovf[k] = 0;
    if (pop) begin
      m_head[k] = (m_head[k] + 1) % DEPTH;
      m_cnt[k]--;
    end
    if (push && !drop) begin
      m_q[k][(m_head[k] + m_cnt[k]) % DEPTH] = {e, w, mt, c};
      m_cnt[k]++;
    end
    m_match[k] = mt;
    m_pc[k]    = int'(c);
    m_prst[k]  = ctr_reset;
  endtask

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic mt, input logic [7:0] wc, input logic se,
                          input logic ov, input logic v, input logic [5:0] d);
    chk($sformatf("i%0d_match", k), int'(mt), m_match[k]);
    chk($sformatf("i%0d_wrap_cnt", k), int'(wc), m_wcnt[k]);
    chk($sformatf("i%0d_seq_err", k), int'(se), m_seq[k]);
    chk($sformatf("i%0d_overflow", k), int'(ov), m_ovf[k]);
    chk($sformatf("i%0d_evt_valid", k), int'(v), (m_cnt[k] > 0) ? 1 : 0);
    if (m_cnt[k] > 0) chk($sformatf("i%0d_evt_data", k), int'(d), int'(m_q[k][m_head[k]]));
    else              chk($sformatf("i%0d_evt_data_idle", k), int'(d), 0);
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, match0, wc0, seq0, ovf0, e0.evt_valid, e0.evt_data);
      cmp_inst(1, match1, wc1, seq1, ovf1, e1.evt_valid, e1.evt_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic cr, input logic [2:0] cv, input logic clr, input logic r);
    ctr_reset = cr; c = cv; clear_err = clr; rdy = r;
    @(posedge clk);
    lc = cv; lr = cr;
    @(negedge clk);
  endtask

  function automatic logic [2:0] nextc();
    return lr ? 3'd0 : lc + 3'd1;
  endfunction

  initial begin
    int n;
    logic [2:0] v;
    reset_n = 1'b0; ctr_reset = 1'b1; c = 3'd0; clear_err = 1'b0; rdy = 1'b0;
    model_clear(0); model_clear(1);
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_match", int'(match0), 0);
    chk("rst_wrap_cnt", int'(wc0), 0);
    chk("rst_seq_err", int'(seq0), 0);
    chk("rst_evt_valid", int'(e0.evt_valid), 0);
    reset_n = 1'b1;

    // 1: clean 0..7,0 count
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      cyc(1'b0, v, 1'b0, 1'b0);
      if (i == 5) chk("t1_match_late", int'(match0), 1);
      if (i == 6) chk("t1_match_pulse", int'(match0), 0);
    end
    cyc(1'b0, 3'd0, 1'b0, 1'b0);
    chk("t1_wrap_cnt", int'(wc0), 1);
    chk("t1_head_match", int'(e0.evt_data), 6'b001101);
    chk("t5_merged_wrap_match", int'(e1.evt_data), 6'b011000);
    cyc(1'b0, 3'd1, 1'b0, 1'b1);
    chk("t1_head_wrap", int'(e0.evt_data), 6'b010000);
    cyc(1'b0, 3'd2, 1'b0, 1'b1);
    chk("t1_drained", int'(e0.evt_valid), 0);
    chk("t1_no_seq_err", int'(seq0), 0);

    // 2: skip 3->5
    cyc(1'b0, 3'd3, 1'b0, 1'b0);
    cyc(1'b0, 3'd5, 1'b0, 1'b0);
    chk("t2_seq_err", int'(seq0), 1);
    chk("t2_err_evt", int'(e0.evt_data), 6'b100101);
    for (int i = 0; i < 4; i++) cyc(1'b0, 3'($urandom_range(7)), 1'b0, 1'b0);
    chk("t2_frozen_head", int'(e0.evt_data), 6'b100101);
    cyc(1'b0, 3'd6, 1'b1, 1'b0);
    chk("t2_cleared", int'(seq0), 0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);

    // 3: ctr_reset at c=4
    cyc(1'b0, 3'd1, 1'b0, 1'b1);
    cyc(1'b0, 3'd2, 1'b0, 1'b1);
    cyc(1'b0, 3'd3, 1'b0, 1'b1);
    chk("t3_wrap_before", int'(wc0), 1);
    cyc(1'b1, 3'd4, 1'b0, 1'b1);
    chk("t3_wrap_cleared", int'(wc0), 0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("t3_no_err", int'(seq0), 0);
    chk("t3_no_evt", int'(e0.evt_valid), 0);

    // 4: overflow, then push+pop while full
    for (int i = 1; i <= 21; i++) cyc(1'b0, 3'(i % 8), 1'b0, 1'b0);
    chk("t4_overflow", int'(ovf0), 1);
    chk("t4_head_first", int'(e0.evt_data), 6'b001101);
    cyc(1'b0, 3'd6, 1'b1, 1'b0);
    chk("t4_ovf_cleared", int'(ovf0), 0);
    cyc(1'b0, 3'd7, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("t4_pushpop_no_ovf", int'(ovf0), 0);
    chk("t4_head_after_pop", int'(e0.evt_data), 6'b010000);
    cyc(1'b0, 3'd1, 1'b0, 1'b1);
    chk("t4_drain_order", int'(e0.evt_data), 6'b001101);
    for (int i = 2; i <= 4; i++) cyc(1'b0, 3'(i), 1'b0, 1'b1);

    // wrap counter saturation
    for (int i = 0; i < 260 * 8; i++) cyc(1'b0, nextc(), 1'b0, 1'b1);
    chk("sat_wrap_cnt", int'(wc0), 255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic cr, clr;
      cr  = ($urandom_range(19) == 0);
      clr = ($urandom_range(24) == 0);
      v   = ($urandom_range(39) == 0) ? 3'($urandom_range(7)) : nextc();
      cyc(cr, v, clr, 1'($urandom_range(1)));
    end

    // 6: async reset with a pending event
    cyc(1'b0, nextc(), 1'b1, 1'b0);
    n = 0;
    while (!e0.evt_valid && n < 40) begin
      cyc(1'b0, nextc(), 1'b0, 1'b0);
      n++;
    end
    chk("t6_pending_valid", int'(e0.evt_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    model_clear(0); model_clear(1);
    chk("t6_valid0", int'(e0.evt_valid), 0);
    chk("t6_data0", int'(e0.evt_data), 0);
    chk("t6_wrap0", int'(wc0), 0);
    chk("t6_match0", int'(match0), 0);
    chk("t6_seq0", int'(seq0), 0);
    chk("t6_ovf0", int'(ovf0), 0);
    chk("t6_valid1", int'(e1.evt_valid), 0);
    chk("t6_wrap1", int'(wc1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 3'(i % 8), 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
